// File: rtl/weight_stream_ram.sv
// Dual-use weight RAM: Avalon-MM CPU port plus a sequential stream reader with one-beat-per-cycle throughput.
// Optional WEIGHT_STREAM_RAM_LOOP_EN adds st_loop to restart the stream from its base without a bubble.
module weight_stream_ram #(
    parameter int    DATA_W    = 32,
    parameter int    ADDR_W    = 6,
    parameter string INIT_FILE = ""
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   avs_address,
    input  logic                avs_chipselect,
    input  logic                avs_write,
    input  logic                avs_read,
    input  logic [DATA_W-1:0]   avs_writedata,
    input  logic [DATA_W/8-1:0] avs_byteenable,
    output logic [DATA_W-1:0]   avs_readdata,
    output logic                avs_readdatavalid,
    input  logic                st_start,
    input  logic [ADDR_W-1:0]   st_base,
    input  logic [ADDR_W:0]     st_len,
`ifdef WEIGHT_STREAM_RAM_LOOP_EN
    input  logic                st_loop,
`endif
    output logic [DATA_W-1:0]   st_data,
    output logic                st_valid,
    input  logic                st_ready,
    output logic                st_last,
    output logic                st_busy,
    output logic                st_done
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int NB    = DATA_W/8;

    typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state, state_n;
    logic [ADDR_W-1:0] base_q, addr_q, strm_rd_addr;
    logic [ADDR_W:0]   len_q, idx_q;
    logic              ld_start, advance, reload, finish, zero_done;
    logic              strm_rd_en, last_beat, loop_en, cpu_rd;

`ifdef WEIGHT_STREAM_RAM_LOOP_EN
    assign loop_en = st_loop;
`else
    assign loop_en = 1'b0;
`endif

    assign cpu_rd    = avs_chipselect & avs_read & ~avs_write;
    assign last_beat = (idx_q == len_q - 1'b1);
    assign st_valid  = (state == STREAM);
    assign st_busy   = (state != IDLE);
    assign st_last   = st_valid & last_beat;

    // Byte-lane writes; memory is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (avs_chipselect && avs_write)
            for (int b = 0; b < NB; b++)
                if (avs_byteenable[b])
                    mem[avs_address][b*8 +: 8] <= avs_writedata[b*8 +: 8];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs_readdatavalid <= 1'b0;
            avs_readdata      <= '0;
        end else begin
            avs_readdatavalid <= cpu_rd;
            if (cpu_rd)
                avs_readdata <= mem[avs_address];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n   = state;
        ld_start  = 1'b0;
        advance   = 1'b0;
        reload    = 1'b0;
        finish    = 1'b0;
        zero_done = 1'b0;
        case (state)
            IDLE: begin
                if (st_start) begin
                    if (st_len != '0) begin
                        ld_start = 1'b1;
                        state_n  = PRIME;
                    end else begin
                        zero_done = 1'b1;
                    end
                end
            end
            PRIME: state_n = STREAM;
            STREAM: begin
                if (st_ready) begin
                    if (!last_beat) begin
                        advance = 1'b1;
                    end else if (loop_en) begin
                        reload = 1'b1;
                    end else begin
                        finish  = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // The next beat is fetched on the same edge that retires the current one, so no bubble appears.
    assign strm_rd_en   = ld_start | advance | reload;
    assign strm_rd_addr = ld_start ? st_base : (reload ? base_q : addr_q + 1'b1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q  <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            st_data <= '0;
            st_done <= 1'b0;
        end else begin
            st_done <= finish | zero_done;
            if (ld_start) begin
                base_q <= st_base;
                len_q  <= st_len;
            end
            if (strm_rd_en) begin
                addr_q  <= strm_rd_addr;
                st_data <= mem[strm_rd_addr];
            end
            if (ld_start || reload) idx_q <= '0;
            else if (advance)       idx_q <= idx_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_weight_stream_ram.sv
// Directed bench for weight_stream_ram: CPU byte-lane access, streaming, stalls, wrap, zero length, reset, optional loop.
module tb_weight_stream_ram;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [5:0]  avs_address;
    logic        avs_chipselect, avs_write, avs_read;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic        st_start;
    logic [5:0]  st_base;
    logic [6:0]  st_len;
`ifdef WEIGHT_STREAM_RAM_LOOP_EN
    logic        st_loop;
`endif
    logic [31:0] st_data;
    logic        st_valid, st_ready, st_last, st_busy, st_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    weight_stream_ram #(.DATA_W(32), .ADDR_W(6)) dut (
        .clk(clk), .reset_n(reset_n),
        .avs_address(avs_address), .avs_chipselect(avs_chipselect),
        .avs_write(avs_write), .avs_read(avs_read),
        .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
        .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
        .st_start(st_start), .st_base(st_base), .st_len(st_len),
`ifdef WEIGHT_STREAM_RAM_LOOP_EN
        .st_loop(st_loop),
`endif
        .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
        .st_last(st_last), .st_busy(st_busy), .st_done(st_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
        avs_chipselect = 1'b1; avs_write = 1'b1;
        avs_address = a; avs_writedata = d; avs_byteenable = be;
        tick();
        avs_chipselect = 1'b0; avs_write = 1'b0;
    endtask

    task automatic start(input logic [5:0] b, input logic [6:0] l);
        st_base = b; st_len = l; st_start = 1'b1;
        tick();
        st_start = 1'b0;
    endtask

    initial begin
        logic [3:0] pat;
        int beats;
        reset_n = 1'b0;
        avs_address = '0; avs_chipselect = 1'b0; avs_write = 1'b0; avs_read = 1'b0;
        avs_writedata = '0; avs_byteenable = '0;
        st_start = 1'b0; st_base = '0; st_len = '0; st_ready = 1'b0;
`ifdef WEIGHT_STREAM_RAM_LOOP_EN
        st_loop = 1'b0;
`endif
        #1;
        chk("rst_valid", st_valid, 1'b0);
        chk("rst_busy", st_busy, 1'b0);
        chk("rst_done", st_done, 1'b0);
        chk("rst_last", st_last, 1'b0);
        chk("rst_rdv", avs_readdatavalid, 1'b0);
        chk("rst_rdata", avs_readdata, 32'h0);
        chk("rst_sdata", st_data, 32'h0);
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // Byte-lane merge then read with one-cycle latency
        cpu_write(6'd5, 32'hDEADBEEF, 4'hF);
        cpu_write(6'd5, 32'h00001234, 4'h3);
        avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = 6'd5;
        chk("rd_valid_early", avs_readdatavalid, 1'b0);
        tick();
        avs_chipselect = 1'b0; avs_read = 1'b0;
        chk("rd_valid", avs_readdatavalid, 1'b1);
        chk("rd_data", avs_readdata, 32'hDEAD1234);
        tick();
        chk("rd_valid_drop", avs_readdatavalid, 1'b0);
        chk("rd_data_hold", avs_readdata, 32'hDEAD1234);

        for (int i = 0; i < 64; i++) cpu_write(6'(i), 32'(i), 4'hF);

        // Base 2, len 4, sink always ready, concurrent CPU read of 40
        st_ready = 1'b1;
        start(6'd2, 7'd4);
        chk("prime_busy", st_busy, 1'b1);
        chk("prime_valid", st_valid, 1'b0);
        tick();
        chk("b0_valid", st_valid, 1'b1);
        chk("b0_data", st_data, 32'd2);
        chk("b0_last", st_last, 1'b0);
        avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = 6'd40;
        tick();
        avs_chipselect = 1'b0; avs_read = 1'b0;
        chk("b1_data", st_data, 32'd3);
        chk("cc_rdv", avs_readdatavalid, 1'b1);
        chk("cc_rdata", avs_readdata, 32'd40);
        tick();
        chk("b2_data", st_data, 32'd4);
        chk("b2_last", st_last, 1'b0);
        tick();
        chk("b3_data", st_data, 32'd5);
        chk("b3_last", st_last, 1'b1);
        chk("b3_done", st_done, 1'b0);
        tick();
        chk("end_valid", st_valid, 1'b0);
        chk("end_done", st_done, 1'b1);
        chk("end_busy", st_busy, 1'b0);
        tick();
        chk("done_pulse", st_done, 1'b0);

        // Wrap-around: 62,63,0,1
        start(6'd62, 7'd4);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("wrap_valid", st_valid, 1'b1);
            chk("wrap_data", st_data, 32'((62 + i) % 64));
            chk("wrap_last", st_last, (i == 3) ? 1'b1 : 1'b0);
            tick();
        end
        chk("wrap_done", st_done, 1'b1);

        // Backpressure: ready pattern 1,0,0,1 repeating
        pat = 4'b1001;
        beats = 0;
        start(6'd10, 7'd4);
        tick();
        for (int c = 0; c < 20; c++) begin
            st_ready = pat[c % 4];
            chk("stall_valid", st_valid, 1'b1);
            chk("stall_data", st_data, 32'(10 + beats));
            chk("stall_last", st_last, (beats == 3) ? 1'b1 : 1'b0);
            tick();
            if (st_ready) beats++;
            if (beats == 4) break;
        end
        chk("stall_beats", beats, 4);
        chk("stall_end_valid", st_valid, 1'b0);
        chk("stall_done", st_done, 1'b1);
        st_ready = 1'b1;
        tick();

        // Stream read and CPU write to the same word on the same edge: stream sees old data
        avs_chipselect = 1'b1; avs_write = 1'b1; avs_address = 6'd20;
        avs_writedata = 32'h0000AA55; avs_byteenable = 4'hF;
        start(6'd20, 7'd1);
        avs_chipselect = 1'b0; avs_write = 1'b0;
        tick();
        chk("rbw_data", st_data, 32'd20);
        chk("rbw_last", st_last, 1'b1);
        tick();
        chk("rbw_done", st_done, 1'b1);
        avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = 6'd20;
        tick();
        avs_chipselect = 1'b0; avs_read = 1'b0;
        chk("rbw_mem", avs_readdata, 32'h0000AA55);

        // Zero-length start
        start(6'd0, 7'd0);
        chk("z_valid", st_valid, 1'b0);
        chk("z_busy", st_busy, 1'b0);
        chk("z_done", st_done, 1'b1);
        tick();
        chk("z_done_drop", st_done, 1'b0);
        chk("z_valid2", st_valid, 1'b0);

        // Start while busy is ignored; reset mid-stream abandons without done
        start(6'd0, 7'd8);
        st_base = 6'd30; st_len = 7'd2; st_start = 1'b1;
        tick();
        st_start = 1'b0;
        chk("busy_ign_data", st_data, 32'd0);
        tick();
        chk("busy_ign_data1", st_data, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mrst_valid", st_valid, 1'b0);
        chk("mrst_busy", st_busy, 1'b0);
        chk("mrst_sdata", st_data, 32'h0);
        tick();
        chk("mrst_done", st_done, 1'b0);
        reset_n = 1'b1;
        tick();
        chk("mrst_done2", st_done, 1'b0);
        avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = 6'd3;
        tick();
        avs_chipselect = 1'b0; avs_read = 1'b0;
        chk("mem_kept", avs_readdata, 32'd3);

`ifdef WEIGHT_STREAM_RAM_LOOP_EN
        st_loop = 1'b1;
        start(6'd0, 7'd2);
        tick();
        for (int i = 0; i < 6; i++) begin
            chk("loop_valid", st_valid, 1'b1);
            chk("loop_data", st_data, 32'(i % 2));
            chk("loop_last", st_last, (i % 2 == 1) ? 1'b1 : 1'b0);
            chk("loop_done", st_done, 1'b0);
            tick();
        end
        st_loop = 1'b0;
        tick();
        chk("unloop_last", st_last, 1'b1);
        tick();
        chk("unloop_valid", st_valid, 1'b0);
        chk("unloop_done", st_done, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
